// File: rtl/arb_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic [0:0] {
        IDLE,
        GRANT
    } arb_state_e;

    // Pointer starts at 3 so requester 0 is scanned first after reset.
    localparam logic [IDX_W-1:0] LAST_RST = 2'd3;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] id);
        return N_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter_4_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_id;
    logic             gnt_v;
    logic             timeout;

    modport master (output req, input gnt, gnt_id, gnt_v, timeout);
    modport slave  (input req, output gnt, gnt_id, gnt_v, timeout);

endinterface

// File: rtl/rr_arbiter_4_pick.sv
// rr_pick4: combinational round-robin pick; scans last+1 .. last (mod 4),
// optionally ignoring one requester.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    input  logic             excl_en,
    input  logic [IDX_W-1:0] excl_id,
    output logic [IDX_W-1:0] pick_id,
    output logic             pick_v
);

    logic [N_REQ-1:0]   cand;
    logic [N_REQ-1:0]   rot;
    logic [2*N_REQ-1:0] dbl;
    logic [IDX_W-1:0]   start;
    logic [IDX_W-1:0]   enc;

    assign cand  = req & ~(excl_en ? onehot(excl_id) : '0);
    assign start = last + 2'd1;

    // Doubling the vector turns the rotate into a plain right shift.
    assign dbl = {cand, cand} >> start;
    assign rot = dbl[N_REQ-1:0];

    always_comb begin
        enc = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) enc = IDX_W'(i);
        end
    end

    assign pick_id = start + enc;
    assign pick_v  = |rot;

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with grant locking.
// ARB_TIMEOUT_EN adds a MAX_HOLD-cycle force-release of a contended grant.
//
// state | meaning
// IDLE  | no grant; arbitrate any request on the next edge
// GRANT | gnt_id holds the resource until it drops req (or times out)
module rr_arbiter_4
    import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
    parameter int MAX_HOLD = 16
)
`endif
(
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter_4_if.slave bus
);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] gnt_id_q, gnt_id_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] pick_id;
    logic [IDX_W-1:0] pick_last;
    logic             pick_v;
    logic             holding;
    logic             force_rel;

    assign holding   = bus.req[gnt_id_q];
    assign pick_last = (state_q == GRANT) ? gnt_id_q : last_q;

    // In GRANT the holder is always excluded: on a normal release its req is
    // already low, and on a force-release it must not win again.
    rr_pick4 u_pick (
        .req     (bus.req),
        .last    (pick_last),
        .excl_en (state_q == GRANT),
        .excl_id (gnt_id_q),
        .pick_id (pick_id),
        .pick_v  (pick_v)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int               HOLD_W   = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_cnt_q;
    logic              timeout_q;
    logic              new_gnt;

    assign force_rel = (state_q == GRANT) && holding && (hold_cnt_q == HOLD_MAX)
                     && |(bus.req & ~onehot(gnt_id_q));
    assign new_gnt   = pick_v && ((state_q == IDLE) || !holding || force_rel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= force_rel;
            if (new_gnt)
                hold_cnt_q <= '0;
            else if (state_q == GRANT && hold_cnt_q != HOLD_MAX)
                hold_cnt_q <= hold_cnt_q + 1'b1;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign force_rel   = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        case (state_q)
            IDLE: begin
                if (pick_v) begin
                    state_d  = GRANT;
                    gnt_d    = onehot(pick_id);
                    gnt_id_d = pick_id;
                end
            end
            GRANT: begin
                if (!holding || force_rel) begin
                    last_d = gnt_id_q;
                    if (pick_v) begin
                        gnt_d    = onehot(pick_id);
                        gnt_id_d = pick_id;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= LAST_RST;
            gnt_q    <= '0;
            gnt_id_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.gnt_id = gnt_id_q;
    assign bus.gnt_v  = |gnt_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Scoreboard bench for rr_arbiter_4; build with +define+ARB_TIMEOUT_EN for the timeout variant.
module tb_rr_arbiter_4;

`ifdef ARB_TIMEOUT_EN
    localparam bit TOUT_EN  = 1'b1;
`else
    localparam bit TOUT_EN  = 1'b0;
`endif
    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    rr_arbiter_4_if bus ();

`ifdef ARB_TIMEOUT_EN
    rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
    rr_arbiter_4 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       gv;
        logic       tout;
    } exp_t;

    exp_t sbq[$];

    bit         m_busy;
    int         m_last;
    int         m_id;
    int         m_cnt;
    logic [3:0] m_gnt;
    logic       m_tout;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int model_pick(input logic [3:0] r, input int last, input bit excl, input int ex);
        for (int off = 1; off <= 4; off++) begin
            int idx;
            idx = (last + off) % 4;
            if (r[idx] && !(excl && idx == ex)) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_last = 3;
        m_id   = 0;
        m_cnt  = 0;
        m_gnt  = 4'b0000;
        m_tout = 1'b0;
        sbq.delete();
    endtask

    task automatic model_step(input logic [3:0] r);
        int  p;
        bit  forced;
        m_tout = 1'b0;
        if (!m_busy) begin
            p = model_pick(r, m_last, 1'b0, 0);
            if (p >= 0) begin
                m_busy = 1'b1;
                m_id   = p;
                m_gnt  = 4'b0001 << p;
                m_cnt  = 0;
            end
        end else begin
            forced = TOUT_EN && r[m_id] && (m_cnt == MAX_HOLD - 1) && ((r & ~(4'b0001 << m_id)) != 4'b0000);
            if (!r[m_id] || forced) begin
                m_last = m_id;
                m_tout = forced;
                p = model_pick(r, m_id, 1'b1, m_id);
                if (p >= 0) begin
                    m_id  = p;
                    m_gnt = 4'b0001 << p;
                    m_cnt = 0;
                end else begin
                    m_busy = 1'b0;
                    m_gnt  = 4'b0000;
                end
            end else if (m_cnt < MAX_HOLD - 1) begin
                m_cnt++;
            end
        end
    endtask

    task automatic step(input logic [3:0] r);
        exp_t e;
        @(negedge clk);
        bus.req = r;
        model_step(r);
        e.gnt  = m_gnt;
        e.id   = 2'(m_id);
        e.gv   = |m_gnt;
        e.tout = m_tout;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            chk_eq("gnt", bus.gnt, e.gnt);
            chk_eq("gnt_id", bus.gnt_id, e.id);
            chk_eq("gnt_v", bus.gnt_v, e.gv);
            chk_eq("timeout", bus.timeout, e.tout);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.req = 4'b0000;
        rst_n   = 1'b0;
        #2;
        chk_eq("rst_gnt", bus.gnt, 4'b0000);
        chk_eq("rst_gnt_id", bus.gnt_id, 2'd0);
        chk_eq("rst_gnt_v", bus.gnt_v, 1'b0);
        chk_eq("rst_timeout", bus.timeout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [3:0] r;
        bus.req = 4'b0000;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // first arbitration and back-to-back handoff
        step(4'b1111);
        chk_eq("first_gnt", bus.gnt, 4'b0001);
        step(4'b1110);
        chk_eq("handoff_gnt", bus.gnt, 4'b0010);
        chk_eq("handoff_id", bus.gnt_id, 2'd1);

        // fairness: each holder keeps the grant two cycles, then drops once
        do_reset();
        step(4'b1111);
        chk_eq("fair_id0", bus.gnt_id, 2'd0);
        for (int i = 1; i <= 4; i++) begin
            step(4'b1111);
            r = 4'b1111 & ~(4'b0001 << (i - 1));
            step(r);
            chk_eq("fair_id", bus.gnt_id, 32'(i % 4));
        end

        // lock against competing requests
        do_reset();
        step(4'b0100);
        for (int i = 0; i < 10; i++) begin
            step(4'b1111);
            if (!TOUT_EN || i < MAX_HOLD - 2) begin
                chk_eq("lock_gnt", bus.gnt, 4'b0100);
                chk_eq("lock_gnt_v", bus.gnt_v, 1'b1);
            end
        end

        // idle return keeps gnt_id, then wrap to requester 3
        do_reset();
        step(4'b1000);
        step(4'b0000);
        chk_eq("idle_gnt", bus.gnt, 4'b0000);
        chk_eq("idle_gnt_v", bus.gnt_v, 1'b0);
        chk_eq("idle_gnt_id", bus.gnt_id, 2'd3);
        step(4'b1000);
        chk_eq("wrap_gnt", bus.gnt, 4'b1000);

        // asynchronous reset between edges while granted
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("arst_gnt", bus.gnt, 4'b0000);
        chk_eq("arst_gnt_v", bus.gnt_v, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0110);
        chk_eq("post_arst_gnt", bus.gnt, 4'b0010);

`ifdef ARB_TIMEOUT_EN
        do_reset();
        repeat (MAX_HOLD) step(4'b0011);
        chk_eq("pre_tout_gnt", bus.gnt, 4'b0001);
        chk_eq("pre_tout", bus.timeout, 1'b0);
        step(4'b0011);
        chk_eq("tout_pulse", bus.timeout, 1'b1);
        chk_eq("tout_gnt", bus.gnt, 4'b0010);
        step(4'b0011);
        chk_eq("tout_once", bus.timeout, 1'b0);
        do_reset();
        repeat (10) step(4'b0001);
        chk_eq("sole_gnt", bus.gnt, 4'b0001);
        chk_eq("sole_tout", bus.timeout, 1'b0);
`endif

        // random traffic with sticky requests
        do_reset();
        r = 4'b0000;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 0) r = 4'($urandom_range(0, 15));
            step(r);
            chk_eq("onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter with grant locking; shares one downstream resource, such as a bus port or shared datapath, between requesters.
- The winner is chosen by rotating the request vector and applying a 4-to-2 priority encode from the rotation point.
- The grant stays registered and locked until the holder drops its request.
- The encoded grant index and valid flag mirror the priority-encoder output convention (q/v), but are registered.

Parameters:
- N_REQ, 4, number of requesters; fixed at 4 for this block, kept as a parameter for documentation and package alignment.
- MAX_HOLD, 16, maximum consecutive grant cycles per holder; used only when ARB_TIMEOUT_EN is defined; legal range 2..256.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req  input  4  request vector; bit i = requester i.
- gnt  output  4  one-hot grant, registered; all-zero when idle.
- gnt_id  output  2  encoded index of current grant holder, registered.
- gnt_v  output  1  high when any grant is active; equals |gnt.
- timeout  output  1  one-cycle pulse when a hold is force-released; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values:
  - gnt=4'b0000, gnt_id=2'd0, gnt_v=0, timeout=0.
  - state=IDLE.
  - last pointer = 2'd3, so requester 0 has highest priority on the first arbitration.
- Pick function (combinational):
  - Scan order is last+1, last+2, last+3, last, modulo 4, wrapping.
  - The first set req bit in scan order wins.
  - "none" when req==0.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0, go to GRANT next edge: gnt=onehot(pick), gnt_id=pick, gnt_v=1.
  - Latency from req assertion to gnt is exactly 1 cycle.
  - Otherwise stay in IDLE, outputs 0.
- GRANT, holder h = gnt_id:
  - req[h]=1: hold grant unchanged; ignore all other requests.
  - req[h]=0: update last=h and re-pick in the same edge.
    - If a winner exists, gnt moves directly to it with no idle bubble (back-to-back handoff).
    - Else go to IDLE and clear gnt/gnt_v. gnt_id holds its last value.
- Release of the grant is sampled on the same edge the holder's req is seen low; the holder loses gnt one cycle after deasserting req.
- Requests arriving during a lock are not queued; they are evaluated at the next arbitration point.
- Simultaneous requests: resolved purely by rotation from last. No requester waits more than 3 arbitrations.
- gnt is never multi-hot, and never granted to a requester whose req was 0 at the deciding edge.
- Reset mid-grant: outputs drop asynchronously to reset values; last returns to 3.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Hold counter hold_cnt, width $clog2(MAX_HOLD), clears on every new grant and increments each GRANT cycle.
  - Force-release condition: hold_cnt==MAX_HOLD-1 and req[h]=1 and some other req bit is set.
  - On force-release: re-pick with h excluded, set last=h, pulse timeout=1 for one cycle.
  - If h is the sole requester, the grant continues and the counter saturates at MAX_HOLD-1 without pulsing timeout.
- Undefined: no counter, timeout constant 0, grant locks indefinitely.

Decomposition:
- Package arb_pkg holds:
  - localparam N_REQ=4 and IDX_W=2.
  - Typedef arb_state_e {IDLE, GRANT}.
  - Reset constant LAST_RST=2'd3.
- Sub-module rr_pick4 (combinational):
  - Inputs: req[3:0], last[1:0], excl_en, excl_id[1:0].
  - Outputs: pick_id[1:0], pick_v.
  - Implementation: rotate, 4-to-2 priority encode, un-rotate.
- rr_arbiter_4 owns the FSM, registers and the hold counter.

Test Plan:
- Reset then req=4'b1111 -> 1 cycle later gnt=0001, gnt_id=0. Drop req[0] -> next edge gnt=0010, gnt_id=1, no idle cycle.
- Round-robin fairness: hold req=1111 and each holder drops/reasserts after 2 cycles -> grant sequence 0,1,2,3,0. No requester is skipped.
- Lock: grant to 2 with req=0100, then raise req=1111 for 10 cycles with req[2] held -> gnt stays 0100, gnt_v=1 throughout.
- Idle return: sole holder 3 drops req with req=0000 -> next edge gnt=0000, gnt_v=0, gnt_id=3. Then req=1000 -> gnt=1000 (wrap, last=3).
- Async reset asserted mid-GRANT between clock edges -> gnt=0, gnt_v=0 immediately. After release with req=0110 -> gnt=0010.
- ARB_TIMEOUT_EN, MAX_HOLD=4:
  - Holder 0 keeps req with req=0011 -> after 4 grant cycles, timeout pulses once and gnt=0010.
  - With req=0001 only -> no timeout and gnt stays 0001.
